fabric_rx_checker: RTL and testbench

//  Receive-side endpoint of the node fabric link. Accepts flits from a router local port or a peer

---
 rtl/pgnoc_pkg.sv | 19 +
 rtl/fabric_rx_flit_check.sv | 30 +++
 rtl/fabric_rx_checker.sv | 139 +++++++++++++
 tb/tb_fabric_rx_checker.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pgnoc_pkg.sv
// Shared fabric definitions: flit field offsets and the receive-checker FSM state type.
package pgnoc_pkg;

  typedef enum logic [1:0] {IDLE, RECV, DRAIN, COMMIT} rx_state_t;

  // Flit layout, MSB first: {last, dst_addr, payload}
  function automatic int flit_last_bit(input int data_size, input int addr_size);
    return data_size + addr_size;
  endfunction

  function automatic int flit_addr_lsb(input int data_size, input int addr_size);
    return data_size + 0 * addr_size;
  endfunction

  function automatic int flit_data_lsb(input int data_size, input int addr_size);
    return 0 * (data_size + addr_size);
  endfunction

endpackage

// File: rtl/fabric_rx_flit_check.sv
// Per-flit rule check: destination address, expected payload and length headroom.
module fabric_rx_flit_check
  import pgnoc_pkg::*;
#(
  parameter int DATA_SIZE    = 4,
  parameter int ADDR_SIZE    = 1,
  parameter int ADDR         = 0,
  parameter int MAX_PACK_LEN = 10,
  parameter int LEN_W        = $clog2(MAX_PACK_LEN + 1)
) (
  input  logic [DATA_SIZE+ADDR_SIZE:0] flit,
  input  logic [DATA_SIZE-1:0]         exp,
  input  logic [LEN_W-1:0]             len,
  output logic                         addr_ok,
  output logic                         data_ok,
  output logic                         len_ok
);

  localparam int ADDR_LSB = flit_addr_lsb(DATA_SIZE, ADDR_SIZE);
  localparam int DATA_LSB = flit_data_lsb(DATA_SIZE, ADDR_SIZE);
  localparam logic [LEN_W:0] MAX_L = (LEN_W + 1)'(MAX_PACK_LEN);

  // len counts flits already accepted; this flit would make it len + 1
  always_comb begin
    addr_ok = (flit[ADDR_LSB +: ADDR_SIZE] == ADDR_SIZE'(ADDR));
    data_ok = (flit[DATA_LSB +: DATA_SIZE] == exp);
    len_ok  = (({1'b0, len} + (LEN_W + 1)'(1)) <= MAX_L);
  end

endmodule

// File: rtl/fabric_rx_checker.sv
// Fabric receive endpoint: reassembles packets, checks traffic rules, counts good/bad packets.
// Define FABRIC_RX_LOG_EN to print a simulation log of commits and first failing checks.
module fabric_rx_checker
  import pgnoc_pkg::*;
#(
  parameter int DATA_SIZE     = 4,
  parameter int ADDR_SIZE     = 1,
  parameter int ADDR          = 0,
  parameter int MAX_PACK_LEN  = 10,
  parameter int PACKS_TO_RECV = 10,
  parameter int CNT_W         = 8
) (
  input  logic                         clk,
  input  logic                         a_rst,
  input  logic [DATA_SIZE+ADDR_SIZE:0] data_i,
  input  logic                         in_w,
  output logic                         in_r,
  output logic [CNT_W-1:0]             pack_cnt,
  output logic [CNT_W-1:0]             err_cnt,
  output logic                         err,
  output logic                         done
);

  localparam int LEN_W    = $clog2(MAX_PACK_LEN + 1);
  localparam int LAST_BIT = flit_last_bit(DATA_SIZE, ADDR_SIZE);
  localparam logic [CNT_W:0] PACKS_L = (CNT_W + 1)'(PACKS_TO_RECV);

  rx_state_t            state, state_n;
  logic [LEN_W-1:0]     len_q, len_n, chk_len;
  logic [DATA_SIZE-1:0] exp_q, exp_n, chk_exp;
  logic                 bad_q, bad_n;
  logic                 accept, last, ok;
  logic                 addr_ok, data_ok, len_ok;
  logic [CNT_W-1:0]     pack_nxt, err_nxt;
  logic [CNT_W:0]       sum_nxt;

  // Flit 0 is checked against a fresh packet context rather than the stale registers
  assign chk_len = (state == IDLE) ? '0 : len_q;
  assign chk_exp = (state == IDLE) ? '0 : exp_q;

  fabric_rx_flit_check #(
    .DATA_SIZE   (DATA_SIZE),
    .ADDR_SIZE   (ADDR_SIZE),
    .ADDR        (ADDR),
    .MAX_PACK_LEN(MAX_PACK_LEN),
    .LEN_W       (LEN_W)
  ) u_check (
    .flit   (data_i),
    .exp    (chk_exp),
    .len    (chk_len),
    .addr_ok(addr_ok),
    .data_ok(data_ok),
    .len_ok (len_ok)
  );

  always_comb begin
    state_n = state;
    len_n   = len_q;
    exp_n   = exp_q;
    bad_n   = bad_q;
    in_r    = (state != COMMIT) && !a_rst;
    accept  = in_w && in_r;
    last    = data_i[LAST_BIT];
    ok      = addr_ok && data_ok && len_ok;
    case (state)
      IDLE, RECV: begin
        if (accept) begin
          len_n = chk_len + LEN_W'(1);
          exp_n = chk_exp + DATA_SIZE'(1);
          if (!ok) begin
            bad_n   = 1'b1;
            state_n = last ? COMMIT : DRAIN;
          end else begin
            bad_n   = 1'b0;
            state_n = last ? COMMIT : RECV;
          end
        end
      end
      DRAIN:   if (accept && last) state_n = COMMIT;
      COMMIT:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Saturating counter candidates, used only while in COMMIT
  always_comb begin
    pack_nxt = pack_cnt;
    err_nxt  = err_cnt;
    if (!bad_q && !(&pack_cnt)) pack_nxt = pack_cnt + CNT_W'(1);
    if (bad_q && !(&err_cnt))   err_nxt  = err_cnt + CNT_W'(1);
    sum_nxt = {1'b0, pack_nxt} + {1'b0, err_nxt};
  end

  always_ff @(posedge clk) begin
    if (a_rst) begin
      state    <= IDLE;
      len_q    <= '0;
      exp_q    <= '0;
      bad_q    <= 1'b0;
      pack_cnt <= '0;
      err_cnt  <= '0;
      err      <= 1'b0;
      done     <= 1'b0;
    end else begin
      state <= state_n;
      len_q <= len_n;
      exp_q <= exp_n;
      bad_q <= bad_n;
      if (state == COMMIT) begin
        pack_cnt <= pack_nxt;
        err_cnt  <= err_nxt;
        err      <= err | bad_q;
        if (sum_nxt >= PACKS_L) done <= 1'b1;
      end
    end
  end

`ifdef FABRIC_RX_LOG_EN
  always_ff @(posedge clk) begin
    if (!a_rst) begin
      if (state == COMMIT)
        $display("%0t fabric_rx[%0d]: %s packet len=%0d", $time, ADDR,
                 bad_q ? "bad" : "good", len_q);
      if (accept && (state == IDLE || state == RECV) && !ok) begin
        if (!addr_ok)
          $display("%0t fabric_rx[%0d]: addr check exp=%0d got=%0d", $time, ADDR, ADDR,
                   data_i[LAST_BIT-1 -: ADDR_SIZE]);
        else if (!data_ok)
          $display("%0t fabric_rx[%0d]: payload check exp=%0d got=%0d", $time, ADDR, chk_exp,
                   data_i[DATA_SIZE-1:0]);
        else
          $display("%0t fabric_rx[%0d]: length check max=%0d got=%0d", $time, ADDR,
                   MAX_PACK_LEN, chk_len + LEN_W'(1));
      end
    end
  end
`endif

endmodule

// File: tb/tb_fabric_rx_checker.sv
// Bench for fabric_rx_checker: two instances (MAX_PACK_LEN 10/16, PACKS_TO_RECV 10/2) on one stream.
module tb_fabric_rx_checker;

  localparam int FW = 6;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          a_rst = 1'b1;
  logic [FW-1:0] data_i = '0;
  logic          in_w = 1'b0;
  logic          in_r_a, in_r_b;
  logic [CW-1:0] pack_a, err_a, pack_b, err_b;
  logic          errf_a, done_a, errf_b, done_b;

  always #5 clk = ~clk;

  fabric_rx_checker #(.MAX_PACK_LEN(10), .PACKS_TO_RECV(10)) dut_a (
    .clk(clk), .a_rst(a_rst), .data_i(data_i), .in_w(in_w), .in_r(in_r_a),
    .pack_cnt(pack_a), .err_cnt(err_a), .err(errf_a), .done(done_a)
  );

  fabric_rx_checker #(.MAX_PACK_LEN(16), .PACKS_TO_RECV(2)) dut_b (
    .clk(clk), .a_rst(a_rst), .data_i(data_i), .in_w(in_w), .in_r(in_r_b),
    .pack_cnt(pack_b), .err_cnt(err_b), .err(errf_b), .done(done_b)
  );

  typedef struct packed {logic good_a; logic good_b;} exp_t;
  exp_t sb[$];

  int total = 0;
  int bad   = 0;

  // Reference model, owned by the monitor
  int   m_pack_a = 0, m_err_a = 0, m_pack_b = 0, m_err_b = 0;
  logic m_errf_a = 0, m_done_a = 0, m_errf_b = 0, m_done_b = 0;
  exp_t mon_e;
  logic ld1 = 1'b0, ld2 = 1'b0;

  // ld1: last flit accepted at previous edge (now in COMMIT); ld2: counters just updated
  always @(posedge clk) begin
    if (a_rst) begin
      ld1 <= 1'b0;
      ld2 <= 1'b0;
    end else begin
      ld1 <= in_w & in_r_a & data_i[FW-1];
      ld2 <= ld1;
    end
  end

  always @(negedge clk) begin
    if (a_rst) begin
      m_pack_a = 0; m_err_a = 0; m_pack_b = 0; m_err_b = 0;
      m_errf_a = 0; m_done_a = 0; m_errf_b = 0; m_done_b = 0;
    end
    if (ld1) begin
      total++;
      if (in_r_a !== 1'b0 || in_r_b !== 1'b0) begin
        bad++;
        $display("FAIL commit_ready: in_r a=%b b=%b, want 0", in_r_a, in_r_b);
      end
    end
    if (ld2) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL sb_empty: commit seen with no expected packet");
      end else begin
        mon_e = sb.pop_front();
        if (mon_e.good_a) m_pack_a++; else begin m_err_a++; m_errf_a = 1; end
        if (mon_e.good_b) m_pack_b++; else begin m_err_b++; m_errf_b = 1; end
        if (m_pack_a + m_err_a >= 10) m_done_a = 1;
        if (m_pack_b + m_err_b >= 2)  m_done_b = 1;
        if (pack_a !== CW'(m_pack_a) || err_a !== CW'(m_err_a) || errf_a !== m_errf_a ||
            done_a !== m_done_a || pack_b !== CW'(m_pack_b) || err_b !== CW'(m_err_b) ||
            errf_b !== m_errf_b || done_b !== m_done_b || in_r_a !== 1'b1) begin
          bad++;
          $display("FAIL commit_counts: a got p=%0d e=%0d err=%b done=%b want p=%0d e=%0d err=%b done=%b | b got p=%0d e=%0d err=%b done=%b want p=%0d e=%0d err=%b done=%b | in_r=%b",
                   pack_a, err_a, errf_a, done_a, m_pack_a, m_err_a, m_errf_a, m_done_a,
                   pack_b, err_b, errf_b, done_b, m_pack_b, m_err_b, m_errf_b, m_done_b, in_r_a);
        end
      end
    end
  end

  // Called and returns at a negedge; holds the flit until the DUT takes it
  task automatic send_flit(input logic [FW-1:0] f);
    int guard = 0;
    data_i = f;
    in_w   = 1'b1;
    while (in_r_a !== 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 20) begin
      total++; bad++;
      $display("FAIL stall: in_r stuck at %b, want 1", in_r_a);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  // kind 0 corrupts dst_addr of flit bad_idx, kind 1 corrupts its payload
  task automatic send_pkt(input int n, input int bad_idx, input int kind, input bit gaps,
                          input bit hold);
    exp_t       e;
    logic       lb, ab;
    logic [3:0] pb;
    e.good_a = (bad_idx < 0) && (n <= 10);
    e.good_b = (bad_idx < 0) && (n <= 16);
    sb.push_back(e);
    for (int k = 0; k < n; k++) begin
      lb = (k == n - 1);
      ab = (k == bad_idx && kind == 0);
      pb = k[3:0] ^ ((k == bad_idx && kind == 1) ? 4'h5 : 4'h0);
      send_flit({lb, ab, pb});
      if (gaps && k < n - 1) begin
        in_w = 1'b0;
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
    end
    if (!hold) in_w = 1'b0;
  endtask

  task automatic wait_drain();
    int g = 0;
    in_w = 1'b0;
    while ((sb.size() != 0 || ld1 || ld2) && g < 40) begin
      @(negedge clk);
      g++;
    end
    @(negedge clk);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d packets never committed, want 0", sb.size());
    end
  endtask

  task automatic test_reset();
    a_rst  = 1'b1;
    in_w   = 1'b1;
    data_i = 6'b1_0_0000;
    @(negedge clk);
    @(negedge clk);
    total++;
    if ({pack_a, err_a, errf_a, done_a, in_r_a, pack_b, err_b, errf_b, done_b, in_r_b} !== '0) begin
      bad++;
      $display("FAIL reset_state: a p=%0d e=%0d err=%b done=%b in_r=%b b p=%0d e=%0d err=%b done=%b in_r=%b, want all 0",
               pack_a, err_a, errf_a, done_a, in_r_a, pack_b, err_b, errf_b, done_b, in_r_b);
    end
    in_w  = 1'b0;
    a_rst = 1'b0;
    @(negedge clk);
    total++;
    if (in_r_a !== 1'b1 || pack_a !== '0) begin
      bad++;
      $display("FAIL reset_release: in_r=%b pack=%0d, want 1 and 0", in_r_a, pack_a);
    end
  endtask

  task automatic test_basic();
    send_pkt(3, -1, 0, 1'b0, 1'b0);
    wait_drain();
    total++;
    if (pack_a !== 8'd1 || err_a !== 8'd0 || errf_a !== 1'b0) begin
      bad++;
      $display("FAIL basic: pack=%0d err_cnt=%0d err=%b, want 1 0 0", pack_a, err_a, errf_a);
    end
  endtask

  task automatic test_single();
    send_pkt(1, -1, 0, 1'b0, 1'b0);
    wait_drain();
    total++;
    if (pack_a !== 8'd2 || done_b !== 1'b1 || done_a !== 1'b0) begin
      bad++;
      $display("FAIL single: pack=%0d done_b=%b done_a=%b, want 2 1 0", pack_a, done_b, done_a);
    end
  endtask

  task automatic test_bad_flits();
    send_pkt(4, 1, 0, 1'b0, 1'b0);
    wait_drain();
    total++;
    if (err_a !== 8'd1 || errf_a !== 1'b1 || pack_a !== 8'd2) begin
      bad++;
      $display("FAIL bad_addr: err_cnt=%0d err=%b pack=%0d, want 1 1 2", err_a, errf_a, pack_a);
    end
    send_pkt(5, 3, 1, 1'b0, 1'b0);
    send_pkt(3, 0, 0, 1'b0, 1'b0);
    wait_drain();
    total++;
    if (err_a !== 8'd3 || pack_a !== 8'd2) begin
      bad++;
      $display("FAIL bad_payload: err_cnt=%0d pack=%0d, want 3 2", err_a, pack_a);
    end
  endtask

  task automatic test_length();
    send_pkt(11, -1, 0, 1'b0, 1'b0);
    send_pkt(10, -1, 0, 1'b0, 1'b0);
    send_pkt(16, -1, 0, 1'b0, 1'b0);
    send_pkt(17, -1, 0, 1'b0, 1'b0);
    wait_drain();
    total++;
    if (err_a !== 8'd6 || pack_a !== 8'd3 || pack_b !== 8'd5 || err_b !== 8'd4) begin
      bad++;
      $display("FAIL length: a p=%0d e=%0d b p=%0d e=%0d, want 3 6 5 4", pack_a, err_a, pack_b, err_b);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    for (int p = 0; p < 8; p++) begin
      n = $urandom_range(1, 6);
      send_pkt(n, (p == 3) ? int'($urandom_range(0, n - 1)) : -1, 1, p[0], p != 7);
    end
    wait_drain();
  endtask

  task automatic test_reset_mid();
    send_flit(6'b0_0_0000);
    send_flit(6'b0_0_0001);
    in_w  = 1'b0;
    a_rst = 1'b1;
    @(negedge clk);
    total++;
    if ({pack_a, err_a, errf_a, done_a, in_r_a, pack_b, err_b, errf_b, done_b} !== '0) begin
      bad++;
      $display("FAIL mid_reset: a p=%0d e=%0d err=%b done=%b in_r=%b b p=%0d e=%0d err=%b done=%b, want all 0",
               pack_a, err_a, errf_a, done_a, in_r_a, pack_b, err_b, errf_b, done_b);
    end
    a_rst = 1'b0;
    @(negedge clk);
    send_pkt(2, -1, 0, 1'b0, 1'b0);
    wait_drain();
    total++;
    if (pack_a !== 8'd1 || err_a !== 8'd0 || errf_a !== 1'b0 || done_b !== 1'b0) begin
      bad++;
      $display("FAIL post_reset: pack=%0d err_cnt=%0d err=%b done_b=%b, want 1 0 0 0",
               pack_a, err_a, errf_a, done_b);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_single();
    test_bad_flits();
    test_length();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
